// File: rtl/fmap_serializer.sv
// fmap_serializer
//   Captures a pooled feature map from a flat parallel bus in a single cycle.
//   It then streams the map one element per valid/ready transfer toward the
//   sequential fully-connected stage. An optional ReLU is applied to each
//   element on the way out.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   start      capture request; honoured only while idle
//   data       pooled map; element idx lives at data[idx*BITWIDTH +: BITWIDTH]
//   busy       high from capture through the done pulse
//   out_data   current element (ReLU applied when RELU_EN != 0)
//   out_index  flat index of out_data
//   out_valid  element offered
//   out_ready  consumer accepts the offered element
//   out_last   high with out_valid on element NUM-1
//   done       one-cycle pulse after the final transfer
module fmap_serializer #(
    parameter  int BITWIDTH    = 16,
    parameter  int DATAWIDTH   = 7,
    parameter  int DATAHEIGHT  = 7,
    parameter  int DATACHANNEL = 4,
    parameter  int RELU_EN     = 1,
    localparam int NUM         = DATAWIDTH * DATAHEIGHT * DATACHANNEL,
    localparam int IW          = (NUM > 1) ? $clog2(NUM) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [BITWIDTH*NUM-1:0] data,
    output logic                    busy,
    output logic [BITWIDTH-1:0]     out_data,
    output logic [IW-1:0]           out_index,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_last,
    output logic                    done
);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        FIN
    } state_t;

    localparam logic [IW-1:0] LAST = IW'(NUM - 1);

    state_t              state;
    logic [BITWIDTH-1:0] cap [NUM];
    logic [IW-1:0]       idx;
    logic [IW-1:0]       idx_next;
    logic [BITWIDTH-1:0] elem_next;

    function automatic logic [BITWIDTH-1:0] relu(input logic [BITWIDTH-1:0] e);
        if ((RELU_EN != 0) && e[BITWIDTH-1]) begin
            return '0;
        end
        return e;
    endfunction

    // The next element is looked up ahead of time so that out_data can be
    // registered. The wrap to 0 on the last index keeps the array lookup in
    // range; that value is never used.
    always_comb begin
        idx_next  = (idx == LAST) ? '0 : idx + 1'b1;
        elem_next = cap[idx_next];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            for (int unsigned i = 0; i < NUM; i++) begin
                cap[i] <= '0;
            end
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            done      <= 1'b0;
            out_data  <= '0;
            out_index <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        for (int unsigned i = 0; i < NUM; i++) begin
                            cap[i] <= data[i*BITWIDTH +: BITWIDTH];
                        end
                        idx       <= '0;
                        out_index <= '0;
                        out_data  <= relu(data[BITWIDTH-1:0]);
                        out_valid <= 1'b1;
                        out_last  <= (NUM == 1);
                        busy      <= 1'b1;
                        state     <= SEND;
                    end
                end
                SEND: begin
                    // out_valid is constantly high here, so out_ready alone marks a transfer.
                    if (out_ready) begin
                        if (idx == LAST) begin
                            state     <= FIN;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            done      <= 1'b1;
                            idx       <= '0;
                            out_index <= '0;
                            out_data  <= '0;
                        end else begin
                            idx       <= idx_next;
                            out_index <= idx_next;
                            out_data  <= relu(elem_next);
                            out_last  <= (idx_next == LAST);
                        end
                    end
                end
                FIN: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fmap_serializer.sv
// tb_fmap_serializer
//   Self-checking bench for fmap_serializer. Two instances share every input:
//   dut uses ReLU and dut0 passes values through unchanged. Expected streams
//   come from a queue built out of the stimulus pattern.
module tb_fmap_serializer;

    localparam int BW    = 16;
    localparam int NUM   = 196;
    localparam int IW    = 8;
    localparam int LIMIT = 5 * NUM + 20;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [BW*NUM-1:0] data;
    logic              out_ready;

    logic              busy, out_valid, out_last, done;
    logic [BW-1:0]     out_data;
    logic [IW-1:0]     out_index;
    logic              busy0, out_valid0, out_last0, done0;
    logic [BW-1:0]     out_data0;
    logic [IW-1:0]     out_index0;

    int checks   = 0;
    int failures = 0;

    logic [BW-1:0] pat_a [NUM];
    logic [BW-1:0] pat_b [NUM];

    typedef struct {
        logic [BW-1:0] elem;
        logic [BW-1:0] exp_relu;
        logic [BW-1:0] exp_pass;
    } vec_t;

    vec_t vecs [6];

    fmap_serializer #(
        .BITWIDTH(16), .DATAWIDTH(7), .DATAHEIGHT(7), .DATACHANNEL(4), .RELU_EN(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .data(data), .busy(busy),
        .out_data(out_data), .out_index(out_index), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last), .done(done)
    );

    fmap_serializer #(
        .BITWIDTH(16), .DATAWIDTH(7), .DATAHEIGHT(7), .DATACHANNEL(4), .RELU_EN(0)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .data(data), .busy(busy0),
        .out_data(out_data0), .out_index(out_index0), .out_valid(out_valid0),
        .out_ready(out_ready), .out_last(out_last0), .done(done0)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [BW-1:0] ref_relu(input logic [BW-1:0] e);
        return ($signed(e) < 0) ? '0 : e;
    endfunction

    task automatic load(input bit use_b);
        for (int i = 0; i < NUM; i++) begin
            data[i*BW +: BW] = use_b ? pat_b[i] : pat_a[i];
        end
    endtask

    function automatic logic ready_of(input int mode, input int cyc);
        case (mode)
            0:       return 1'b1;
            1:       return ((cyc % 4) == 0) || ((cyc % 4) == 3);
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    // Runs one stream of pat_a. start_at >= 0 re-pulses start with pat_b once
    // that many elements have transferred. abort_at >= 0 applies reset while
    // that element is being offered.
    task automatic run_stream(input int mode, input int start_at, input int abort_at);
        logic [BW-1:0] expq [$];
        int            k;
        int            dones;
        bit            stalled;
        bit            fin;
        bit            injected;
        logic [BW-1:0] hd;
        logic [IW-1:0] hi;
        logic          hl;
        k = 0; dones = 0; stalled = 0; fin = 0; injected = 0;
        hd = '0; hi = '0; hl = 1'b0;
        for (int i = 0; i < NUM; i++) expq.push_back(ref_relu(pat_a[i]));
        load(0);
        out_ready = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int cyc = 0; cyc < LIMIT && !fin; cyc++) begin
            out_ready = ready_of(mode, cyc);
            if (dones > 0) begin
                chk("busy_after_done", busy, 0);
                chk("done_width", done, 0);
                chk("valid_after_done", out_valid, 0);
                fin = 1;
            end else if (done) begin
                dones++;
                chk("busy_at_done", busy, 1);
                chk("valid_at_done", out_valid, 0);
                chk("last_at_done", out_last, 0);
                chk("transfers_at_done", k, NUM);
                chk("raw_done", done0, 1);
                if (mode == 0) chk("done_latency", cyc, NUM);
            end else begin
                chk("busy", busy, 1);
                chk("valid_no_bubble", out_valid, k < NUM);
                if (stalled) begin
                    chk("stall_data", out_data, hd);
                    chk("stall_index", out_index, hi);
                    chk("stall_last", out_last, hl);
                end
                if (abort_at == k && out_valid) begin
                    rst_n = 1'b0;
                    step();
                    chk("abort_valid", out_valid, 0);
                    chk("abort_index", out_index, 0);
                    chk("abort_busy", busy, 0);
                    chk("abort_done", done, 0);
                    rst_n = 1'b1;
                    for (int j = 0; j < 4; j++) begin
                        step();
                        chk("post_abort_idle", {busy, out_valid, done}, 0);
                    end
                    return;
                end
                if (out_valid) begin
                    chk("last_flag", out_last, k == NUM - 1);
                    if (out_ready) begin
                        if (k < NUM) begin
                            chk("data", out_data, expq.pop_front());
                            chk("raw_data", out_data0, pat_a[k]);
                            chk("index", out_index, k);
                        end else begin
                            chk("extra_transfer", 1, 0);
                        end
                        k++;
                        stalled = 0;
                    end else begin
                        stalled = 1;
                        hd = out_data; hi = out_index; hl = out_last;
                    end
                end
                if (start_at >= 0 && k == start_at && !injected) begin
                    injected = 1;
                    load(1);
                    start = 1'b1;
                end
            end
            if (!fin) begin
                step();
                start = 1'b0;
            end
        end
        chk("stream_finished", fin, 1);
        chk("transfer_count", k, NUM);
        chk("done_count", dones, 1);
    endtask

    initial begin
        vecs[0] = '{16'h8000, 16'h0000, 16'h8000};
        vecs[1] = '{16'h7FFF, 16'h7FFF, 16'h7FFF};
        vecs[2] = '{16'hFFFF, 16'h0000, 16'hFFFF};
        vecs[3] = '{16'h0000, 16'h0000, 16'h0000};
        vecs[4] = '{16'h0001, 16'h0001, 16'h0001};
        vecs[5] = '{16'hC3A5, 16'h0000, 16'hC3A5};

        rst_n = 1'b0; start = 1'b1; out_ready = 1'b1; data = '0;
        for (int i = 0; i < NUM; i++) pat_a[i] = 16'($urandom);
        load(0);

        // Reset held with start asserted: nothing may be captured.
        for (int j = 0; j < 2; j++) begin
            step();
            chk("reset_outputs", {busy, out_valid, done, out_last}, 0);
            chk("reset_data", out_data, 0);
            chk("reset_index", out_index, 0);
        end
        rst_n = 1'b1; start = 1'b0;
        for (int j = 0; j < 3; j++) begin
            step();
            chk("idle_after_reset", {busy, out_valid, done}, 0);
        end

        // First element through both ReLU settings, aborted by reset each time.
        foreach (vecs[v]) begin
            for (int i = 0; i < NUM; i++) pat_a[i] = 16'($urandom);
            pat_a[0] = vecs[v].elem;
            load(0);
            start = 1'b1;
            step();
            start = 1'b0;
            chk("vec_valid", out_valid, 1);
            chk("vec_index", out_index, 0);
            chk("vec_relu", out_data, vecs[v].exp_relu);
            chk("vec_pass", out_data0, vecs[v].exp_pass);
            rst_n = 1'b0;
            step();
            rst_n = 1'b1;
            step();
        end

        // Ramp i-98, with the consumer always ready.
        for (int i = 0; i < NUM; i++) pat_a[i] = 16'(i - 98);
        run_stream(0, -1, -1);

        // Ready toggling 1,0,0,1 on a random map.
        for (int i = 0; i < NUM; i++) pat_a[i] = 16'($urandom);
        run_stream(1, -1, -1);

        // Second start with a different map partway through the stream.
        for (int i = 0; i < NUM; i++) begin
            pat_a[i] = 16'($urandom);
            pat_b[i] = ~pat_a[i];
        end
        run_stream(2, 50, -1);
        step();

        // Reset at element 100, then a fresh stream from index 0.
        for (int i = 0; i < NUM; i++) pat_a[i] = 16'($urandom);
        run_stream(0, -1, 100);
        for (int i = 0; i < NUM; i++) pat_a[i] = 16'($urandom);
        run_stream(0, -1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
